// File: rtl/fetch_unit_if.sv
// Instruction fetch bus bundle: hazard/redirect control in, shared-RAM read port, IF/ID outputs.
// Latency: n/a (wires only).
// Backpressure: if_PAUSE freezes IF/ID; mem_busy/mem_ready stall the RAM read.
//
// Signals
//   if_PAUSE            hazard stall from the pipeline
//   jump_en, jump_addr  redirect request and target from EXE
//   mem_busy            MEM stage owns the shared RAM this cycle
//   mem_ready/mem_rdata instruction read data valid / data
//   mem_req/mem_addr    instruction read request / address
//   id_inst/id_PC       registered instruction and fetch address + 1 to ID
//   id_valid            id_inst is a real fetched instruction
//   fetch_err           sticky memory-timeout flag
interface fetch_unit_if;
    logic        if_PAUSE;
    logic        jump_en;
    logic [15:0] jump_addr;
    logic        mem_busy;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] id_inst;
    logic [15:0] id_PC;
    logic        id_valid;
    logic        fetch_err;

    // Fetch unit side
    modport master (
        input  if_PAUSE, jump_en, jump_addr, mem_busy, mem_ready, mem_rdata,
        output mem_req, mem_addr, id_inst, id_PC, id_valid, fetch_err
    );

    // Pipeline / memory side
    modport slave (
        output if_PAUSE, jump_en, jump_addr, mem_busy, mem_ready, mem_rdata,
        input  mem_req, mem_addr, id_inst, id_PC, id_valid, fetch_err
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads the shared RAM at pc and registers the word into IF/ID.
// Latency: 1 cycle from a completed read (mem_req & mem_ready) to id_inst/id_PC/id_valid.
// Backpressure: if_PAUSE freezes IF/ID; a read completing under pause is parked in a one-entry hold buffer.
//
// Ports
//   clk_50MHz  clock, rising edge
//   rst        asynchronous active-low reset
//   bus        fetch_unit_if.master (control in, RAM read port, IF/ID outputs, fetch_err)
module fetch_unit #(
    parameter logic [15:0] PC_RESET   = 16'h0000,
    parameter logic [15:0] NOP_INST   = 16'h0800,
    parameter logic [3:0]  WAIT_LIMIT = 4'd15
) (
    input  logic          clk_50MHz,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_id_inst;
    logic [15:0] r_id_pc;
    logic        r_id_valid;
    logic [3:0]  r_wait_cnt;
    logic        r_fetch_err;
    logic [15:0] r_hold_inst;
    logic [15:0] r_hold_pc;

    logic        w_mem_req;
    logic        w_fetch_done;
    logic [15:0] w_pc_inc;

    // A redirect kills the request in the same cycle so the RAM is never read
    // for an address that is about to be abandoned.
    assign w_mem_req    = (r_state == ST_FETCH) && !bus.mem_busy && !bus.jump_en;
    assign w_fetch_done = w_mem_req && bus.mem_ready;
    assign w_pc_inc     = r_pc + 16'd1;

    assign bus.mem_req   = w_mem_req;
    assign bus.mem_addr  = r_pc;
    assign bus.id_inst   = r_id_inst;
    assign bus.id_PC     = r_id_pc;
    assign bus.id_valid  = r_id_valid;
    assign bus.fetch_err = r_fetch_err;

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_BOOT;
            r_pc        <= PC_RESET;
            r_id_inst   <= NOP_INST;
            r_id_pc     <= 16'h0000;
            r_id_valid  <= 1'b0;
            r_wait_cnt  <= 4'd0;
            r_fetch_err <= 1'b0;
            r_hold_inst <= 16'h0000;
            r_hold_pc   <= 16'h0000;
        end else begin
            // Flag rises one edge after the counter sits at the limit and
            // never clears; the counter itself may be cleared on this edge.
            if (r_wait_cnt == WAIT_LIMIT) begin
                r_fetch_err <= 1'b1;
            end

            if (bus.jump_en && (r_state != ST_BOOT)) begin
                // Redirect wins over pause and any read data this cycle.
                r_pc        <= bus.jump_addr;
                r_id_inst   <= NOP_INST;
                r_id_valid  <= 1'b0;
                r_hold_inst <= 16'h0000;
                r_hold_pc   <= 16'h0000;
                r_wait_cnt  <= 4'd0;
                r_state     <= ST_FETCH;
            end else begin
                case (r_state)
                    ST_BOOT: begin
                        // One idle cycle after reset; an early redirect still lands.
                        if (bus.jump_en) begin
                            r_pc <= bus.jump_addr;
                        end
                        r_state <= ST_FETCH;
                    end

                    ST_FETCH: begin
                        if (w_fetch_done) begin
                            r_wait_cnt <= 4'd0;
                            r_pc       <= w_pc_inc;
                            if (bus.if_PAUSE) begin
                                // ID cannot take it yet: park the word so it is
                                // neither lost nor fetched twice.
                                r_hold_inst <= bus.mem_rdata;
                                r_hold_pc   <= w_pc_inc;
                                r_state     <= ST_HOLD;
                            end else begin
                                r_id_inst  <= bus.mem_rdata;
                                r_id_pc    <= w_pc_inc;
                                r_id_valid <= 1'b1;
                            end
                        end else begin
                            if (bus.mem_busy) begin
                                r_wait_cnt <= 4'd0;
                            end else if (r_wait_cnt != WAIT_LIMIT) begin
                                r_wait_cnt <= r_wait_cnt + 4'd1;
                            end
                            // Bubble into ID; id_PC keeps the last real value.
                            if (!bus.if_PAUSE) begin
                                r_id_inst  <= NOP_INST;
                                r_id_valid <= 1'b0;
                            end
                        end
                    end

                    ST_HOLD: begin
                        // No new request until the parked word has drained.
                        if (!bus.if_PAUSE) begin
                            r_id_inst  <= r_hold_inst;
                            r_id_pc    <= r_hold_pc;
                            r_id_valid <= 1'b1;
                            r_state    <= ST_FETCH;
                        end
                    end

                    default: begin
                        r_state <= ST_BOOT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences, randomized run against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0800;
    localparam int          WL  = 15;

    logic clk_50MHz = 1'b0;
    logic rst;
    logic [15:0] mem_key = 16'hA000;

    always #10 clk_50MHz = ~clk_50MHz;

    fetch_unit_if bus ();

    // RAM: word at address a is a ^ mem_key, returned combinationally.
    assign bus.mem_rdata = bus.mem_addr ^ mem_key;

    fetch_unit #(
        .PC_RESET   (16'h0000),
        .NOP_INST   (16'h0800),
        .WAIT_LIMIT (4'd15)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic j, input logic [15:0] ja, input logic b, input logic r);
        bus.if_PAUSE  = p;
        bus.jump_en   = j;
        bus.jump_addr = ja;
        bus.mem_busy  = b;
        bus.mem_ready = r;
    endtask

    task automatic tick();
        @(posedge clk_50MHz);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_pc, m_inst, m_idpc, m_hinst, m_hpc;
    logic        m_boot, m_held, m_valid, m_err;
    int          m_miss;   // consecutive unanswered requests, unsaturated

    function automatic void model_reset();
        m_pc = 16'h0000; m_inst = NOP; m_idpc = 16'h0000; m_valid = 1'b0;
        m_boot = 1'b1; m_held = 1'b0; m_hinst = 16'h0; m_hpc = 16'h0;
        m_miss = 0; m_err = 1'b0;
    endfunction

    function automatic logic model_req(input logic b, input logic j);
        return !m_boot && !m_held && !b && !j;
    endfunction

    function automatic void model_edge(input logic p, input logic j, input logic [15:0] ja,
                                       input logic b, input logic r);
        logic req;
        req = model_req(b, j);
        if (m_miss >= WL) m_err = 1'b1;
        if (m_boot) begin
            m_boot = 1'b0;
            if (j) m_pc = ja;
        end else if (j) begin
            m_pc = ja; m_inst = NOP; m_valid = 1'b0; m_held = 1'b0; m_miss = 0;
        end else if (m_held) begin
            if (!p) begin
                m_inst = m_hinst; m_idpc = m_hpc; m_valid = 1'b1; m_held = 1'b0;
            end
        end else if (req && r) begin
            m_miss = 0;
            if (p) begin
                m_held = 1'b1; m_hinst = m_pc ^ mem_key; m_hpc = m_pc + 16'd1;
            end else begin
                m_inst = m_pc ^ mem_key; m_idpc = m_pc + 16'd1; m_valid = 1'b1;
            end
            m_pc = m_pc + 16'd1;
        end else begin
            if (b) m_miss = 0;
            else   m_miss++;
            if (!p) begin
                m_inst = NOP; m_valid = 1'b0;
            end
        end
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        p, j;
        logic [15:0] ja;
        logic        b, r;
        logic        x_req;
        logic [15:0] x_addr, x_inst, x_pc;
        logic        x_vld;
    } vec_t;

    vec_t tbl[16];

    task automatic run_random(input int n, input int p_pct, input int j_pct,
                              input int b_pct, input int r_pct, input string tag);
        logic p, j, b, r;
        logic [15:0] ja;
        rst = 1'b0;
        drive(0, 0, 16'h0, 0, 0);
        #2;
        model_reset();
        tick();
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            p  = ($urandom_range(0, 99) < p_pct);
            j  = ($urandom_range(0, 99) < j_pct);
            b  = ($urandom_range(0, 99) < b_pct);
            r  = ($urandom_range(0, 99) < r_pct);
            ja = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            drive(p, j, ja, b, r);
            #5;
            chk($sformatf("%s%0d req", tag, i), {15'b0, bus.mem_req}, {15'b0, model_req(b, j)});
            chk($sformatf("%s%0d addr", tag, i), bus.mem_addr, m_pc);
            model_edge(p, j, ja, b, r);
            tick();
            chk($sformatf("%s%0d inst", tag, i), bus.id_inst, m_inst);
            chk($sformatf("%s%0d idpc", tag, i), bus.id_PC, m_idpc);
            chk($sformatf("%s%0d vld", tag, i), {15'b0, bus.id_valid}, {15'b0, m_valid});
            chk($sformatf("%s%0d err", tag, i), {15'b0, bus.fetch_err}, {15'b0, m_err});
        end
    endtask

    initial begin
        //        p  j  ja        b  r   req addr      inst      idpc      vld
        tbl[0]  = '{0, 0, 16'h0000, 0, 1,  0, 16'h0000, 16'h0800, 16'h0000, 0}; // BOOT
        tbl[1]  = '{0, 0, 16'h0000, 0, 1,  1, 16'h0000, 16'hA000, 16'h0001, 1};
        tbl[2]  = '{0, 0, 16'h0000, 0, 1,  1, 16'h0001, 16'hA001, 16'h0002, 1};
        tbl[3]  = '{0, 0, 16'h0000, 0, 1,  1, 16'h0002, 16'hA002, 16'h0003, 1};
        tbl[4]  = '{0, 0, 16'h0000, 0, 1,  1, 16'h0003, 16'hA003, 16'h0004, 1};
        tbl[5]  = '{0, 0, 16'h0000, 0, 1,  1, 16'h0004, 16'hA004, 16'h0005, 1};
        tbl[6]  = '{1, 0, 16'h0000, 0, 1,  1, 16'h0005, 16'hA004, 16'h0005, 1}; // addr 5 parked
        tbl[7]  = '{1, 0, 16'h0000, 0, 1,  0, 16'h0006, 16'hA004, 16'h0005, 1}; // HOLD
        tbl[8]  = '{1, 0, 16'h0000, 0, 1,  0, 16'h0006, 16'hA004, 16'h0005, 1}; // HOLD
        tbl[9]  = '{0, 0, 16'h0000, 0, 1,  0, 16'h0006, 16'hA005, 16'h0006, 1}; // drain
        tbl[10] = '{0, 0, 16'h0000, 0, 1,  1, 16'h0006, 16'hA006, 16'h0007, 1};
        tbl[11] = '{0, 0, 16'h0000, 1, 1,  0, 16'h0007, 16'h0800, 16'h0007, 0}; // busy
        tbl[12] = '{0, 0, 16'h0000, 1, 1,  0, 16'h0007, 16'h0800, 16'h0007, 0}; // busy
        tbl[13] = '{0, 0, 16'h0000, 0, 1,  1, 16'h0007, 16'hA007, 16'h0008, 1};
        tbl[14] = '{1, 1, 16'h0040, 0, 1,  0, 16'h0008, 16'h0800, 16'h0008, 0}; // jump+pause
        tbl[15] = '{0, 0, 16'h0000, 0, 1,  1, 16'h0040, 16'hA040, 16'h0041, 1};

        // Reset values
        rst = 1'b0;
        drive(0, 0, 16'h0, 0, 1);
        repeat (3) tick();
        chk("rst inst", bus.id_inst, NOP);
        chk("rst idpc", bus.id_PC, 16'h0000);
        chk("rst vld", {15'b0, bus.id_valid}, 16'h0000);
        chk("rst err", {15'b0, bus.fetch_err}, 16'h0000);
        chk("rst req", {15'b0, bus.mem_req}, 16'h0000);
        chk("rst addr", bus.mem_addr, 16'h0000);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].p, tbl[i].j, tbl[i].ja, tbl[i].b, tbl[i].r);
            #5;
            chk($sformatf("v%0d req", i), {15'b0, bus.mem_req}, {15'b0, tbl[i].x_req});
            chk($sformatf("v%0d addr", i), bus.mem_addr, tbl[i].x_addr);
            tick();
            chk($sformatf("v%0d inst", i), bus.id_inst, tbl[i].x_inst);
            chk($sformatf("v%0d idpc", i), bus.id_PC, tbl[i].x_pc);
            chk($sformatf("v%0d vld", i), {15'b0, bus.id_valid}, {15'b0, tbl[i].x_vld});
            chk($sformatf("v%0d err", i), {15'b0, bus.fetch_err}, 16'h0000);
        end

        // Timeout: 16 unanswered cycles at addr 0x41
        drive(0, 0, 16'h0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("to%0d vld", k), {15'b0, bus.id_valid}, 16'h0000);
            chk($sformatf("to%0d err", k), {15'b0, bus.fetch_err}, (k == 16) ? 16'h0001 : 16'h0000);
        end
        drive(0, 0, 16'h0, 0, 1);
        tick();
        chk("to done inst", bus.id_inst, 16'hA041);
        chk("to sticky err", {15'b0, bus.fetch_err}, 16'h0001);

        // Wrap at 0xFFFF
        drive(0, 1, 16'hFFFF, 0, 1);
        tick();
        drive(0, 0, 16'h0, 0, 1);
        #5;
        chk("wrap addr ffff", bus.mem_addr, 16'hFFFF);
        tick();
        chk("wrap inst", bus.id_inst, 16'h5FFF);
        chk("wrap idpc", bus.id_PC, 16'h0000);
        #5;
        chk("wrap next addr", bus.mem_addr, 16'h0000);
        tick();   // fetch of addr 0 completes, pc = 1

        // Reset while a word is parked in HOLD
        drive(1, 0, 16'h0, 0, 1);
        tick();
        #5;
        chk("hold req", {15'b0, bus.mem_req}, 16'h0000);
        rst = 1'b0;
        #2;
        chk("hrst vld", {15'b0, bus.id_valid}, 16'h0000);
        chk("hrst inst", bus.id_inst, NOP);
        chk("hrst err", {15'b0, bus.fetch_err}, 16'h0000);
        chk("hrst addr", bus.mem_addr, 16'h0000);
        tick();
        rst = 1'b1;
        drive(0, 0, 16'h0, 0, 1);
        #5;
        chk("boot req", {15'b0, bus.mem_req}, 16'h0000);
        tick();
        chk("post-rst vld", {15'b0, bus.id_valid}, 16'h0000);
        tick();
        chk("post-rst inst", bus.id_inst, 16'hA000);
        chk("post-rst idpc", bus.id_PC, 16'h0001);

        // Randomized runs against the model
        mem_key = 16'h3C5A;
        run_random(1500, 30, 3, 20, 70, "ra");
        mem_key = 16'hA000;
        run_random(1500, 25, 1, 4, 8, "rb");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
